lap_stopwatch: RTL
==================

Name: lap_stopwatch

Overview:
Parametrised stopwatch with lap capture: a centisecond/second/minute/hour counter with run/stop/clear control and a LAP_DEPTH-entry lap register file that can be browsed on the display outputs.
Sits between the external button debouncers, which deliver single-cycle pulses, and the FND display driver.
Adds lap storage, lap browsing, a mode lock and a wrap flag over the plain stopwatch.

Parameters:
TICK_DIV, 1_000_000, clk cycles per centisecond tick (2 or more)
MSEC_MAX, 100, centisecond field modulus
SEC_MAX, 60, second field modulus
MIN_MAX, 60, minute field modulus
HOUR_MAX, 24, hour field modulus
LAP_DEPTH, 8, number of lap entries (2 or more)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
i_run_stop  in  1  one-cycle pulse: toggle run/pause
i_clear  in  1  one-cycle pulse: zero time and laps
i_lap  in  1  one-cycle pulse: capture lap
i_view  in  1  one-cycle pulse: step display source
i_lock  in  1  level; 1 = watch mode, so run_stop/clear/lap are ignored
msec  out  $clog2(MSEC_MAX)  displayed centiseconds
sec  out  $clog2(SEC_MAX)  displayed seconds
min  out  $clog2(MIN_MAX)  displayed minutes
hour  out  $clog2(HOUR_MAX)  displayed hours
o_running  out  1  state == RUN
o_view_lap  out  1  display shows a stored lap
o_lap_idx  out  $clog2(LAP_DEPTH)  lap index currently shown
o_lap_count  out  $clog2(LAP_DEPTH+1)  laps stored
o_lap_full  out  1  o_lap_count == LAP_DEPTH
o_wrap  out  1  one-cycle pulse on full-scale rollover

Behaviour:
- Reset: state IDLE; time, prescaler, laps, view pointer all 0; every output 0.
- FSM states and transitions (registered; effect visible the cycle after the pulse):
  - IDLE --run_stop--> RUN.
  - RUN --run_stop--> STOP.
  - STOP --run_stop--> RUN.
  - STOP --clear--> IDLE.
  - IDLE --clear--> IDLE.
  - Clear is ignored in RUN.
- i_lock=1: run_stop, clear and lap are ignored. Running time keeps counting. View still works.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. Tick fires when prescaler==TICK_DIV-1, then prescaler returns to 0.
  - Holds its value in STOP.
  - Cleared on entry to IDLE.
- Cascade on tick:
  - msec increments; at MSEC_MAX-1 it wraps to 0 and carries into sec; likewise sec into min and min into hour.
  - At hour=HOUR_MAX-1 with all lower fields at max, all fields become 0, o_wrap=1 for one cycle, and RUN continues.
- Lap:
  - Honoured only when state==RUN and lap_count<LAP_DEPTH.
  - Stores the time value present in that cycle (pre-tick value if a tick coincides) at entry lap_count. lap_count increments next cycle.
  - When full, the pulse is dropped and entries are unchanged.
  - A lap and a run_stop in the same cycle: both take effect; the lap captures, then state goes STOP.
- Clear (STOP→IDLE): time, prescaler, lap_count and all entries return to 0; view returns to live.
- View pointer sequence, one step per i_view pulse: live → lap0 → lap1 → … → lap(count-1) → live.
  - Ignored when lap_count==0.
  - In live view o_view_lap=0 and o_lap_idx=0.
  - A new lap capture does not move the pointer.
- Display outputs: combinational mux of registered sources (live counter or selected entry). Zero latency from the pointer register.
- Priority within one cycle: clear > run_stop/lap > view. A view pulse coinciding with clear is discarded.
- Reset mid-count: immediate asynchronous return to reset values.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding localparams IDLE=2'b00, RUN=2'b01, STOP=2'b10;
  - field-width constants derived from the *_MAX parameters.
- One sub-module, time_cascade_counter, contains:
  - the prescaler and the msec/sec/min/hour cascade;
  - inputs: clk, reset, run, clear;
  - outputs: the four fields and wrap.
- Lap register file, view pointer and FSM live in lap_stopwatch.

Test Plan (TICK_DIV=2 for all scenarios):
- Reset, then run_stop pulse, wait 200 clk → sec=1, msec=0, o_running=1.
- Run, lap at time 00:00:00.05, lap at 00:00:00.12, then stop → o_lap_count=2.
  - View pulses show 05, then 12, then live, with o_view_lap 1, 1, 0 and o_lap_idx 0, 1, 0.
- 9 lap pulses with LAP_DEPTH=8 → count=8, o_lap_full=1, entry7 holds the 8th capture, 9th ignored.
- Clear pulse while RUN → no change. Stop, then clear → all fields 0, count 0, state IDLE, and the prescaler restarts from 0 on the next run.
- Force time to 23:59:59.99 and run 2 clk → all fields 0, o_wrap high exactly one cycle, o_running=1.
- i_lock=1 while RUN with run_stop and lap pulses → still running, count unchanged.
  - Async reset asserted mid-count → all outputs 0 immediately.

Source files
------------

// File: rtl/lap_stopwatch_pkg.sv
// Shared constants for the lap stopwatch: FSM encoding, default field moduli, width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STOP = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_STOP = STOP
    } state_t;

    localparam int DEF_TICK_DIV  = 1_000_000;
    localparam int DEF_MSEC_MAX  = 100;
    localparam int DEF_SEC_MAX   = 60;
    localparam int DEF_MIN_MAX   = 60;
    localparam int DEF_HOUR_MAX  = 24;
    localparam int DEF_LAP_DEPTH = 8;

    // Bits needed for a field counting 0..max_v-1 (never narrower than 1).
    function automatic int field_w(input int max_v);
        return (max_v > 1) ? $clog2(max_v) : 1;
    endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Button-pulse inputs and display/status outputs of the lap stopwatch, bundled as one port.
// Latency: n/a (wires only).
// Backpressure: none; inputs are single-cycle pulses plus the i_lock level.
// Ports: master drives i_run_stop/i_clear/i_lap/i_view/i_lock and observes the display;
//        slave (the stopwatch) consumes the pulses and drives msec/sec/min/hour and o_* status.
interface lap_stopwatch_if
    import stopwatch_pkg::*;
#(
    parameter int MSEC_MAX  = DEF_MSEC_MAX,
    parameter int SEC_MAX   = DEF_SEC_MAX,
    parameter int MIN_MAX   = DEF_MIN_MAX,
    parameter int HOUR_MAX  = DEF_HOUR_MAX,
    parameter int LAP_DEPTH = DEF_LAP_DEPTH
);
    logic                               i_run_stop;
    logic                               i_clear;
    logic                               i_lap;
    logic                               i_view;
    logic                               i_lock;
    logic [field_w(MSEC_MAX)-1:0]       msec;
    logic [field_w(SEC_MAX)-1:0]        sec;
    logic [field_w(MIN_MAX)-1:0]        min;
    logic [field_w(HOUR_MAX)-1:0]       hour;
    logic                               o_running;
    logic                               o_view_lap;
    logic [field_w(LAP_DEPTH)-1:0]      o_lap_idx;
    logic [$clog2(LAP_DEPTH+1)-1:0]     o_lap_count;
    logic                               o_lap_full;
    logic                               o_wrap;

    modport master (
        output i_run_stop, i_clear, i_lap, i_view, i_lock,
        input  msec, sec, min, hour, o_running, o_view_lap, o_lap_idx,
               o_lap_count, o_lap_full, o_wrap
    );

    modport slave (
        input  i_run_stop, i_clear, i_lap, i_view, i_lock,
        output msec, sec, min, hour, o_running, o_view_lap, o_lap_idx,
               o_lap_count, o_lap_full, o_wrap
    );
endinterface

// File: rtl/lap_stopwatch_cascade.sv
// Prescaled centisecond/second/minute/hour cascade counter with full-scale wrap pulse.
// Latency: fields and wrap update one clk after the tick or clear that causes them.
// Backpressure: none; run gates counting, clear zeroes everything synchronously.
// Ports: clk, reset (async, active-high), run, clear -> msec, sec, min, hour, wrap.
module time_cascade_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int MSEC_MAX = DEF_MSEC_MAX,
    parameter int SEC_MAX  = DEF_SEC_MAX,
    parameter int MIN_MAX  = DEF_MIN_MAX,
    parameter int HOUR_MAX = DEF_HOUR_MAX
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          clear,
    output logic [field_w(MSEC_MAX)-1:0]  msec,
    output logic [field_w(SEC_MAX)-1:0]   sec,
    output logic [field_w(MIN_MAX)-1:0]   min,
    output logic [field_w(HOUR_MAX)-1:0]  hour,
    output logic                          wrap
);
    localparam int W_MS = field_w(MSEC_MAX);
    localparam int W_S  = field_w(SEC_MAX);
    localparam int W_M  = field_w(MIN_MAX);
    localparam int W_H  = field_w(HOUR_MAX);
    localparam int W_P  = field_w(TICK_DIV);

    logic [W_P-1:0] presc;
    logic           tick;
    logic           ms_end, s_end, m_end, h_end;

    assign tick   = presc == W_P'(TICK_DIV - 1);
    assign ms_end = msec == W_MS'(MSEC_MAX - 1);
    assign s_end  = sec  == W_S'(SEC_MAX - 1);
    assign m_end  = min  == W_M'(MIN_MAX - 1);
    assign h_end  = hour == W_H'(HOUR_MAX - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            msec  <= '0;
            sec   <= '0;
            min   <= '0;
            hour  <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                presc <= '0;
                msec  <= '0;
                sec   <= '0;
                min   <= '0;
                hour  <= '0;
            end else if (run) begin
                if (!tick) begin
                    presc <= presc + 1'b1;
                end else begin
                    presc <= '0;
                    if (!ms_end) begin
                        msec <= msec + 1'b1;
                    end else begin
                        msec <= '0;
                        if (!s_end) begin
                            sec <= sec + 1'b1;
                        end else begin
                            sec <= '0;
                            if (!m_end) begin
                                min <= min + 1'b1;
                            end else begin
                                min <= '0;
                                if (!h_end) begin
                                    hour <= hour + 1'b1;
                                end else begin
                                    // Full-scale rollover: all fields already zeroed above.
                                    hour <= '0;
                                    wrap <= 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            // Not running: prescaler and fields hold (STOP keeps the partial tick).
        end
    end
endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch with run/stop/clear FSM, LAP_DEPTH lap register file and a browsable display source.
// Latency: control/lap/view effects one clk after the pulse; display mux is combinational from registers.
// Backpressure: none; pulses are dropped when locked, in the wrong state, or (laps) when full.
// Ports: clk, reset (async, active-high), sw (lap_stopwatch_if.slave: button pulses in, display/status out).
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int MSEC_MAX  = DEF_MSEC_MAX,
    parameter int SEC_MAX   = DEF_SEC_MAX,
    parameter int MIN_MAX   = DEF_MIN_MAX,
    parameter int HOUR_MAX  = DEF_HOUR_MAX,
    parameter int LAP_DEPTH = DEF_LAP_DEPTH
)(
    input  logic           clk,
    input  logic           reset,
    lap_stopwatch_if.slave sw
);
    localparam int W_MS = field_w(MSEC_MAX);
    localparam int W_S  = field_w(SEC_MAX);
    localparam int W_M  = field_w(MIN_MAX);
    localparam int W_H  = field_w(HOUR_MAX);
    localparam int W_I  = field_w(LAP_DEPTH);
    localparam int W_C  = $clog2(LAP_DEPTH + 1);

    typedef struct packed {
        logic [W_H-1:0]  hour;
        logic [W_M-1:0]  min;
        logic [W_S-1:0]  sec;
        logic [W_MS-1:0] msec;
    } tval_t;

    state_t         state;
    logic           running;
    tval_t          live;
    tval_t          shown;
    tval_t          lap_mem [LAP_DEPTH];
    logic [W_C-1:0] lap_count;
    // 0 = live view, k = lap entry k-1.
    logic [W_C-1:0] view_ptr;
    logic [W_I-1:0] sel;
    logic           view_lap;
    logic           wrap;
    logic           do_toggle, do_clear, do_lap;

    assign do_toggle = sw.i_run_stop && !sw.i_lock;
    assign do_clear  = sw.i_clear && !sw.i_lock && (state != S_RUN);
    assign do_lap    = sw.i_lap && !sw.i_lock && (state == S_RUN) &&
                       (lap_count < W_C'(LAP_DEPTH));

    time_cascade_counter #(
        .TICK_DIV (TICK_DIV),
        .MSEC_MAX (MSEC_MAX),
        .SEC_MAX  (SEC_MAX),
        .MIN_MAX  (MIN_MAX),
        .HOUR_MAX (HOUR_MAX)
    ) u_cascade (
        .clk   (clk),
        .reset (reset),
        .run   (state == S_RUN),
        .clear (do_clear),
        .msec  (live.msec),
        .sec   (live.sec),
        .min   (live.min),
        .hour  (live.hour),
        .wrap  (wrap)
    );

    // Clear outranks run_stop, so a coincident pair in IDLE or STOP lands in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (!do_clear && do_toggle) begin
                    state   <= S_RUN;
                    running <= 1'b1;
                end
                S_RUN: if (do_toggle) begin
                    state   <= S_STOP;
                    running <= 1'b0;
                end
                S_STOP: if (do_clear) begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end else if (do_toggle) begin
                    state   <= S_RUN;
                    running <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Lap capture takes the registered (pre-tick) time; view pulses are swallowed by a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_count <= '0;
            view_ptr  <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
        end else if (do_clear) begin
            lap_count <= '0;
            view_ptr  <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
        end else begin
            if (do_lap) begin
                lap_mem[W_I'(lap_count)] <= live;
                lap_count                <= lap_count + 1'b1;
            end
            if (sw.i_view && (lap_count != '0)) begin
                view_ptr <= (view_ptr == lap_count) ? '0 : view_ptr + 1'b1;
            end
        end
    end

    assign view_lap = view_ptr != '0;
    assign sel      = view_lap ? W_I'(view_ptr - 1'b1) : '0;

    always_comb begin
        shown = live;
        if (view_lap) shown = lap_mem[sel];
    end

    assign sw.msec        = shown.msec;
    assign sw.sec         = shown.sec;
    assign sw.min         = shown.min;
    assign sw.hour        = shown.hour;
    assign sw.o_running   = running;
    assign sw.o_view_lap  = view_lap;
    assign sw.o_lap_idx   = sel;
    assign sw.o_lap_count = lap_count;
    assign sw.o_lap_full  = lap_count == W_C'(LAP_DEPTH);
    assign sw.o_wrap      = wrap;
endmodule
